tile_grid_renderer: RTL and testbench

TILE_GRID_RENDERER -- requirements
Module: tile_grid_renderer

---
 rtl/tile_grid_renderer.sv | 255 +++++++++++++++++++++++++
 tb/tb_tile_grid_renderer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tile_grid_renderer.sv
// Tile grid renderer: 4-bit cell map, clear/flash sequencer, 4-stage RGB444 pixel pipeline.
// Optional macro GRID_LINES_EN draws 12'h222 outlines on empty cells.
module tile_grid_renderer #(
  parameter int GRID_START_X = 800,
  parameter int GRID_START_Y = 330,
  parameter int TILE_LOG2    = 5,
  parameter int COLS         = 10,
  parameter int ROWS         = 20,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [11:0]              hcount_in,
  input  logic [10:0]              vcount_in,
  input  logic                     frame_start_in,
  input  logic                     wr_valid_in,
  output logic                     wr_ready_out,
  input  logic [$clog2(COLS)-1:0]  wr_col_in,
  input  logic [$clog2(ROWS)-1:0]  wr_row_in,
  input  logic [3:0]               wr_color_in,
  input  logic                     clear_start_in,
  input  logic                     flash_start_in,
  input  logic [ROWS-1:0]          flash_mask_in,
  output logic                     busy_out,
  output logic                     done_out,
  output logic [11:0]              pixel_out
);

  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int FC_W   = $clog2(FLASH_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_FLASH = 2'd2
  } state_t;

  function automatic logic [11:0] palette(input logic [2:0] idx);
    logic [11:0] rgb;
    case (idx)
      3'd1:    rgb = 12'hD00;
      3'd2:    rgb = 12'hF63;
      3'd3:    rgb = 12'hFB3;
      3'd4:    rgb = 12'h273;
      3'd5:    rgb = 12'h17D;
      3'd6:    rgb = 12'h969;
      3'd7:    rgb = 12'h267;
      default: rgb = 12'h000;
    endcase
    return rgb;
  endfunction

  state_t             state_r, state_nxt_s;
  logic [ADDR_W-1:0]  clr_addr_r, clr_addr_nxt_s;
  logic [FC_W-1:0]    frame_cnt_r, frame_cnt_nxt_s;
  logic [ROWS-1:0]    mask_r, mask_nxt_s;
  logic               done_r, done_nxt_s;

  logic               wr_ready_s;
  logic               wr_in_range_s;
  logic               mem_we_s;
  logic [ADDR_W-1:0]  mem_waddr_s;
  logic [3:0]         mem_wdata_s;
  logic [3:0]         cell_map_r [CELLS];

  assign wr_ready_s   = (state_r == ST_IDLE);
  assign wr_ready_out = wr_ready_s;
  assign busy_out     = (state_r == ST_CLEAR) || (state_r == ST_FLASH);
  assign done_out     = done_r;

  // Sequencer next-state: clear has priority over flash, starts ignored while busy.
  always_comb begin
    state_nxt_s     = state_r;
    clr_addr_nxt_s  = clr_addr_r;
    frame_cnt_nxt_s = frame_cnt_r;
    mask_nxt_s      = mask_r;
    done_nxt_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clear_start_in) begin
          state_nxt_s    = ST_CLEAR;
          clr_addr_nxt_s = {ADDR_W{1'b0}};
        end else if (flash_start_in && (|flash_mask_in)) begin
          state_nxt_s     = ST_FLASH;
          frame_cnt_nxt_s = {FC_W{1'b0}};
          mask_nxt_s      = flash_mask_in;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_addr_r == ADDR_W'(CELLS - 1)) begin
          state_nxt_s    = ST_IDLE;
          clr_addr_nxt_s = {ADDR_W{1'b0}};
          done_nxt_s     = 1'b1;
        end else begin
          clr_addr_nxt_s = clr_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      ST_FLASH: begin
        if (frame_start_in) begin
          if (frame_cnt_r == FC_W'(FLASH_FRAMES - 1)) begin
            state_nxt_s     = ST_IDLE;
            frame_cnt_nxt_s = {FC_W{1'b0}};
            done_nxt_s      = 1'b1;
          end else begin
            frame_cnt_nxt_s = frame_cnt_r + {{(FC_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_nxt_s = ST_FLASH;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and counters.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r     <= ST_IDLE;
      clr_addr_r  <= {ADDR_W{1'b0}};
      frame_cnt_r <= {FC_W{1'b0}};
      mask_r      <= {ROWS{1'b0}};
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      clr_addr_r  <= clr_addr_nxt_s;
      frame_cnt_r <= frame_cnt_nxt_s;
      mask_r      <= mask_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  // Map write port: the clear sweep owns the port; out-of-range writes are acknowledged but dropped.
  always_comb begin
    wr_in_range_s = (32'(wr_col_in) < COLS) && (32'(wr_row_in) < ROWS);
    mem_we_s      = 1'b0;
    mem_waddr_s   = {ADDR_W{1'b0}};
    mem_wdata_s   = 4'h0;
    if (state_r == ST_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_addr_r;
      mem_wdata_s = 4'h0;
    end else if (wr_valid_in && wr_ready_s && wr_in_range_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = ADDR_W'(32'(wr_row_in) * COLS + 32'(wr_col_in));
      mem_wdata_s = wr_color_in;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Cell map storage; contents deliberately survive reset.
  always_ff @(posedge clk_in) begin
    if (mem_we_s) begin
      cell_map_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  logic [11:0]          hx_s;
  logic [10:0]          vy_s;
  logic                 in_grid_s;
  logic                 edge_s;
  logic [TILE_LOG2-1:0] lx_s, ly_s;
  logic [COL_W-1:0]     col_s;
  logic [ROW_W-1:0]     row_s;
  logic [ADDR_W-1:0]    rd_addr_s;

  logic                 in_grid_p1_r, edge_p1_r;
  logic [ROW_W-1:0]     row_p1_r;
  logic [ADDR_W-1:0]    addr_p1_r;
  logic                 in_grid_p2_r, edge_p2_r;
  logic [ROW_W-1:0]     row_p2_r;
  logic [3:0]           cell_p2_r;
  logic                 in_grid_p3_r;
  logic [11:0]          color_p3_r;
  logic [11:0]          pixel_r;
  logic                 flash_hit_s;
  logic [11:0]          color_s;

  // Stage 1 decode: grid-relative coordinates, tile edge and cell address.
  always_comb begin
    hx_s      = hcount_in - 12'(GRID_START_X);
    vy_s      = vcount_in - 11'(GRID_START_Y);
    in_grid_s = (hcount_in >= 12'(GRID_START_X)) && (hx_s < 12'(COLS << TILE_LOG2)) &&
                (vcount_in >= 11'(GRID_START_Y)) && (vy_s < 11'(ROWS << TILE_LOG2));
    lx_s      = hx_s[TILE_LOG2-1:0];
    ly_s      = vy_s[TILE_LOG2-1:0];
    edge_s    = (lx_s == {TILE_LOG2{1'b0}}) || (lx_s == {TILE_LOG2{1'b1}}) ||
                (ly_s == {TILE_LOG2{1'b0}}) || (ly_s == {TILE_LOG2{1'b1}});
    col_s     = hx_s[TILE_LOG2 +: COL_W];
    row_s     = vy_s[TILE_LOG2 +: ROW_W];
    if (in_grid_s) begin
      rd_addr_s = ADDR_W'(32'(row_s) * COLS + 32'(col_s));
    end else begin
      rd_addr_s = {ADDR_W{1'b0}};
    end
  end

  // Stage 3 colour: flash overrides the whole tile, then empty / ghost / solid styling.
  always_comb begin
    flash_hit_s = (state_r == ST_FLASH) && frame_cnt_r[0] && mask_r[row_p2_r];
    color_s     = 12'h000;
    if (flash_hit_s) begin
      color_s = 12'hFFF;
    end else if (cell_p2_r[2:0] == 3'd0) begin
`ifdef GRID_LINES_EN
      color_s = edge_p2_r ? 12'h222 : 12'h000;
`else
      color_s = 12'h000;
`endif
    end else if (cell_p2_r[3]) begin
      color_s = edge_p2_r ? palette(cell_p2_r[2:0]) : 12'h000;
    end else begin
      color_s = edge_p2_r ? 12'hFFF : palette(cell_p2_r[2:0]);
    end
  end

  // Pixel pipeline registers: decode, map read, colour, output.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      in_grid_p1_r <= 1'b0;
      edge_p1_r    <= 1'b0;
      row_p1_r     <= {ROW_W{1'b0}};
      addr_p1_r    <= {ADDR_W{1'b0}};
      in_grid_p2_r <= 1'b0;
      edge_p2_r    <= 1'b0;
      row_p2_r     <= {ROW_W{1'b0}};
      cell_p2_r    <= 4'h0;
      in_grid_p3_r <= 1'b0;
      color_p3_r   <= 12'h000;
      pixel_r      <= 12'h000;
    end else begin
      in_grid_p1_r <= in_grid_s;
      edge_p1_r    <= edge_s;
      row_p1_r     <= row_s;
      addr_p1_r    <= rd_addr_s;
      in_grid_p2_r <= in_grid_p1_r;
      edge_p2_r    <= edge_p1_r;
      row_p2_r     <= row_p1_r;
      cell_p2_r    <= cell_map_r[addr_p1_r];
      in_grid_p3_r <= in_grid_p2_r;
      color_p3_r   <= color_s;
      pixel_r      <= in_grid_p3_r ? color_p3_r : 12'h000;
    end
  end

  assign pixel_out = pixel_r;

endmodule

// File: tb/tb_tile_grid_renderer.sv
// Directed bench for tile_grid_renderer: pixel vector table plus clear, flash and reset sequences.
module tb_tile_grid_renderer;

`ifdef GRID_LINES_EN
  localparam logic [11:0] EMPTY_EDGE = 12'h222;
`else
  localparam logic [11:0] EMPTY_EDGE = 12'h000;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [11:0] hcount_in;
  logic [10:0] vcount_in;
  logic        frame_start_in;
  logic        wr_valid_in;
  logic        wr_ready_out;
  logic [3:0]  wr_col_in;
  logic [4:0]  wr_row_in;
  logic [3:0]  wr_color_in;
  logic        clear_start_in;
  logic        flash_start_in;
  logic [19:0] flash_mask_in;
  logic        busy_out;
  logic        done_out;
  logic [11:0] pixel_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] h;
    logic [10:0] v;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [15];

  tile_grid_renderer dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .frame_start_in (frame_start_in),
    .wr_valid_in    (wr_valid_in),
    .wr_ready_out   (wr_ready_out),
    .wr_col_in      (wr_col_in),
    .wr_row_in      (wr_row_in),
    .wr_color_in    (wr_color_in),
    .clear_start_in (clear_start_in),
    .flash_start_in (flash_start_in),
    .flash_mask_in  (flash_mask_in),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .pixel_out      (pixel_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic write_cell(input int col, input int row, input logic [3:0] code);
    wr_valid_in = 1'b1;
    wr_col_in   = 4'(col);
    wr_row_in   = 5'(row);
    wr_color_in = code;
    check($sformatf("wr_ready_%0d_%0d", col, row), 32'(wr_ready_out), 32'd1);
    tick();
    wr_valid_in = 1'b0;
  endtask

  // Present the pixel for exactly one cycle, so only the 4-cycle latency sees it.
  task automatic check_pixel(input logic [11:0] h, input logic [10:0] v,
                             input logic [11:0] exp, input string name);
    hcount_in = 12'd0;
    vcount_in = 11'd0;
    repeat (5) tick();
    hcount_in = h;
    vcount_in = v;
    tick();
    hcount_in = 12'd0;
    vcount_in = 11'd0;
    repeat (3) tick();
    check(name, 32'(pixel_out), 32'(exp));
  endtask

  task automatic frame_pulse();
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int done_at;
    int ready_bad;
    int done_bad;

    vecs[0]  = '{12'd800,  11'd330, 12'hFFF};
    vecs[1]  = '{12'd801,  11'd331, 12'hD00};
    vecs[2]  = '{12'd831,  11'd361, 12'hFFF};
    vecs[3]  = '{12'd864,  11'd362, 12'h17D};
    vecs[4]  = '{12'd880,  11'd378, 12'h000};
    vecs[5]  = '{12'd799,  11'd330, 12'h000};
    vecs[6]  = '{12'd1120, 11'd330, 12'h000};
    vecs[7]  = '{12'd800,  11'd329, 12'h000};
    vecs[8]  = '{12'd800,  11'd970, 12'h000};
    vecs[9]  = '{12'd800,  11'd969, EMPTY_EDGE};
    vecs[10] = '{12'd832,  11'd330, EMPTY_EDGE};
    vecs[11] = '{12'd840,  11'd340, 12'h000};
    vecs[12] = '{12'd912,  11'd954, 12'hF63};
    vecs[13] = '{12'd896,  11'd938, 12'hFFF};
    vecs[14] = '{12'd1119, 11'd969, EMPTY_EDGE};

    rst_in = 1'b1;
    hcount_in = 12'd0;
    vcount_in = 11'd0;
    frame_start_in = 1'b0;
    wr_valid_in = 1'b0;
    wr_col_in = 4'd0;
    wr_row_in = 5'd0;
    wr_color_in = 4'd0;
    clear_start_in = 1'b0;
    flash_start_in = 1'b0;
    flash_mask_in = 20'd0;
    repeat (3) tick();
    check("rst_busy",  32'(busy_out),     32'd0);
    check("rst_done",  32'(done_out),     32'd0);
    check("rst_ready", 32'(wr_ready_out), 32'd1);
    check("rst_pixel", 32'(pixel_out),    32'd0);
    rst_in = 1'b0;
    tick();

    // Full clear, with a second clear request mid-sweep that must be ignored.
    clear_start_in = 1'b1;
    tick();
    clear_start_in = 1'b0;
    busy_cnt = 0;
    done_at = -1;
    ready_bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy_out) busy_cnt++;
      if (busy_out && wr_ready_out) ready_bad++;
      if (done_out) begin
        done_at = i;
        break;
      end
      clear_start_in = (i == 10);
      tick();
    end
    clear_start_in = 1'b0;
    check("clear_busy_cycles", 32'(busy_cnt),  32'd200);
    check("clear_done_cycle",  32'(done_at),   32'd200);
    check("clear_ready_low",   32'(ready_bad), 32'd0);
    tick();
    check("clear_done_single", 32'(done_out), 32'd0);
    check("clear_idle",        32'(busy_out), 32'd0);
    check_pixel(12'd801, 11'd331, 12'h000, "clear_cell0");

    write_cell(0, 0, 4'h1);
    write_cell(2, 1, 4'hD);
    write_cell(3, 19, 4'h2);
    write_cell(12, 0, 4'h3);

    for (int i = 0; i < 15; i++) begin
      check_pixel(vecs[i].h, vecs[i].v, vecs[i].exp, $sformatf("pix%0d", i));
    end

    // Flash row 19; restart/clear requests at frame 3 must be ignored.
    flash_mask_in = 20'h80000;
    flash_start_in = 1'b1;
    tick();
    flash_start_in = 1'b0;
    flash_mask_in = 20'd0;
    check("flash_busy", 32'(busy_out), 32'd1);
    check_pixel(12'd912, 11'd954, 12'hF63, "flash_f0");
    for (int f = 1; f <= 8; f++) begin
      frame_pulse();
      check($sformatf("flash_done_f%0d", f), 32'(done_out), 32'(f == 8));
      check($sformatf("flash_busy_f%0d", f), 32'(busy_out), 32'(f != 8));
      if (f == 3) begin
        flash_start_in = 1'b1;
        clear_start_in = 1'b1;
        flash_mask_in = 20'hFFFFF;
        tick();
        flash_start_in = 1'b0;
        clear_start_in = 1'b0;
        flash_mask_in = 20'd0;
      end
      check_pixel(12'd912, 11'd954, ((f % 2) == 1) ? 12'hFFF : 12'hF63,
                  $sformatf("flash_pix_f%0d", f));
      if (f == 1) check_pixel(12'd801, 11'd331, 12'hD00, "flash_unmasked");
    end
    check("flash_idle_after", 32'(done_out), 32'd0);

    // Reset after 50 clear cycles: cells 0..49 zeroed, the rest untouched.
    write_cell(9, 4, 4'h6);
    write_cell(0, 5, 4'h6);
    check_pixel(12'd816, 11'd506, 12'h969, "cell50_pre");
    clear_start_in = 1'b1;
    tick();
    clear_start_in = 1'b0;
    done_bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done_out) done_bad++;
    end
    rst_in = 1'b1;
    tick();
    tick();
    check("abort_no_done", 32'(done_bad),     32'd0);
    check("abort_busy",    32'(busy_out),     32'd0);
    check("abort_ready",   32'(wr_ready_out), 32'd1);
    check("abort_done",    32'(done_out),     32'd0);
    rst_in = 1'b0;
    tick();
    check_pixel(12'd801,  11'd331, 12'h000,    "abort_cell0");
    check_pixel(12'd864,  11'd362, EMPTY_EDGE, "abort_cell12");
    check_pixel(12'd1104, 11'd474, 12'h000,    "abort_cell49");
    check_pixel(12'd816,  11'd506, 12'h969,    "abort_cell50");
    check_pixel(12'd912,  11'd954, 12'hF63,    "abort_cell193");
    check("abort_done_late", 32'(done_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
